lgn_sram_feeder: RTL and testbench

- Read-side streamer that replays a stored input vector from one gf180mcu 512x8 SRAM macro into the LGN byte-load port (write_enable + 8-bit data).
- Sits in chip_core between an SRAM instance and the lgn instance. It replaces the direct pad drive of write_enable/ui_in with an on-chip replay.
- The SRAM is filled by a separate writer. This block only reads.

---
 rtl/lgn_pkg.sv | 20 ++
 rtl/lgn_sram_feeder.sv | 142 ++++++++++++++
 tb/tb_lgn_sram_feeder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lgn_pkg.sv
// Shared types and sizes for the LGN SRAM feeder.
//   feeder_state_t : replay FSM states
//   SRAM_ADDR_W    : address width of the 512x8 SRAM macro
//   SRAM_DEPTH     : word count of the SRAM macro
package lgn_pkg;

    localparam int unsigned SRAM_ADDR_W = 9;
    localparam int unsigned SRAM_DEPTH  = 512;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned GAP_W       = 4;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        EMIT,
        GAP
    } feeder_state_t;

endpackage

// File: rtl/lgn_sram_feeder.sv
// Replays a byte vector stored in a 512x8 SRAM into the LGN byte-load port.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, abort          transfer request / cancel
//   base_addr, length     first SRAM address and byte count, latched on start
//   sram_cen/gwen/wen/a   SRAM read interface (write controls tied inactive)
//   sram_q                SRAM read data, valid the cycle after cen low
//   lgn_we, lgn_data      one-cycle byte strobe and held byte to LGN
//   busy, done            transfer in progress / one-cycle completion pulse
module lgn_sram_feeder
    import lgn_pkg::*;
#(
    parameter int unsigned ADDR_W     = SRAM_ADDR_W,
    parameter int unsigned LEN_W      = 10,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              sram_cen,
    output logic              sram_gwen,
    output logic [BYTE_W-1:0] sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    input  logic [BYTE_W-1:0] sram_q,
    output logic              lgn_we,
    output logic [BYTE_W-1:0] lgn_data,
    output logic              busy,
    output logic              done
);

    // Gap counter counts down from GAP_CYCLES-1 to 0 while in GAP.
    localparam logic [GAP_W-1:0] GAP_LOAD =
        GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    feeder_state_t     state,     state_d;
    logic [ADDR_W-1:0] cur_addr,  cur_addr_d;
    logic [LEN_W-1:0]  remaining, remaining_d;
    logic [GAP_W-1:0]  gap_cnt,   gap_cnt_d;

    logic              sram_cen_d;
    logic [ADDR_W-1:0] sram_a_d;
    logic              lgn_we_d;
    logic [BYTE_W-1:0] lgn_data_d;
    logic              busy_d;
    logic              done_d;

    // The feeder never writes the SRAM.
    assign sram_gwen = 1'b1;
    assign sram_wen  = {BYTE_W{1'b1}};

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            gap_cnt   <= '0;
            sram_cen  <= 1'b1;
            sram_a    <= '0;
            lgn_we    <= 1'b0;
            lgn_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            cur_addr  <= cur_addr_d;
            remaining <= remaining_d;
            gap_cnt   <= gap_cnt_d;
            sram_cen  <= sram_cen_d;
            sram_a    <= sram_a_d;
            lgn_we    <= lgn_we_d;
            lgn_data  <= lgn_data_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Next state, counters, and next values of the registered outputs.
    always_comb begin
        state_d     = state;
        cur_addr_d  = cur_addr;
        remaining_d = remaining;
        gap_cnt_d   = gap_cnt;
        done_d      = 1'b0;

        case (state)
            IDLE: begin
                // start beats a simultaneous abort here.
                if (start) begin
                    if (length != '0) begin
                        state_d     = READ;
                        cur_addr_d  = base_addr;
                        remaining_d = length;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: state_d = CAPT;
            CAPT: state_d = EMIT;
            EMIT: begin
                cur_addr_d  = cur_addr + ADDR_W'(1);
                remaining_d = remaining - LEN_W'(1);
                if (remaining == LEN_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (GAP_CYCLES == 0) begin
                    state_d = READ;
                end else begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_d = READ;
                end else begin
                    gap_cnt_d = gap_cnt - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort drops straight to IDLE without a done pulse; an EMIT strobe
        // already on the port this cycle is unaffected.
        if (abort && (state != IDLE)) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end

        busy_d     = (state_d != IDLE);
        sram_cen_d = (state_d != READ);
        sram_a_d   = (state_d == READ) ? cur_addr_d : sram_a;
        lgn_we_d   = (state_d == EMIT);
        // Data captured from the SRAM only on the CAPT -> EMIT step.
        lgn_data_d = ((state == CAPT) && (state_d == EMIT)) ? sram_q : lgn_data;
    end

endmodule

// File: tb/tb_lgn_sram_feeder.sv
// Scoreboard bench for lgn_sram_feeder with a behavioural 512x8 SRAM.
module tb_lgn_sram_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [8:0] base_addr;
    logic [9:0] length;
    logic       sram_cen;
    logic       sram_gwen;
    logic [7:0] sram_wen;
    logic [8:0] sram_a;
    logic [7:0] sram_q;
    logic       lgn_we;
    logic [7:0] lgn_data;
    logic       busy;
    logic       done;

    logic [7:0] mem [512];

    logic [7:0] exp_data [$];
    logic [8:0] exp_addr [$];

    int vectors     = 0;
    int miscompares = 0;
    int strobes     = 0;

    lgn_sram_feeder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .length    (length),
        .sram_cen  (sram_cen),
        .sram_gwen (sram_gwen),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_q    (sram_q),
        .lgn_we    (lgn_we),
        .lgn_data  (lgn_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // SRAM read model: data appears the cycle after a cen-low cycle.
    always @(posedge clk) begin
        if (sram_cen == 1'b0) sram_q <= mem[sram_a];
    end

    // Advance one cycle, sample #1 after the edge, and service the scoreboard.
    task automatic tick();
        logic [7:0] ed;
        logic [8:0] ea;
        @(posedge clk);
        #1;
        if (lgn_we === 1'b1) begin
            strobes++;
            vectors++;
            if (exp_data.size() == 0) begin
                miscompares++;
                $display("FAIL strobe_unexpected: got data %h, none expected", lgn_data);
            end else begin
                ed = exp_data.pop_front();
                if (lgn_data !== ed) begin
                    miscompares++;
                    $display("FAIL strobe_data: got %h, expected %h", lgn_data, ed);
                end
            end
        end
        if (sram_cen === 1'b0) begin
            vectors++;
            if (exp_addr.size() == 0) begin
                miscompares++;
                $display("FAIL read_unexpected: got addr %0d, none expected", sram_a);
            end else begin
                ea = exp_addr.pop_front();
                if (sram_a !== ea) begin
                    miscompares++;
                    $display("FAIL read_addr: got %0d, expected %0d", sram_a, ea);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
        tick();
        tick();
        vectors++;
        if ({sram_cen, sram_gwen, sram_wen, sram_a, lgn_we, lgn_data, busy, done}
            !== {1'b1, 1'b1, 8'hFF, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: cen=%b gwen=%b wen=%h a=%0d we=%b data=%h busy=%b done=%b",
                     sram_cen, sram_gwen, sram_wen, sram_a, lgn_we, lgn_data, busy, done);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // base 0, length 4, gap 1: strobes at 3,7,11,15, done at 16.
    task automatic test_basic();
        logic ew, ec, eb, edn;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_addr = '{9'd0, 9'd1, 9'd2, 9'd3};
        strobes = 0;
        base_addr = 9'd0; length = 10'd4; start = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            start = 1'b0;
            ew  = (k >= 3 && k <= 15 && ((k - 3) % 4) == 0);
            ec  = !(k >= 1 && k <= 13 && ((k - 1) % 4) == 0);
            eb  = (k >= 1 && k <= 15);
            edn = (k == 16);
            vectors++;
            if ({lgn_we, sram_cen, busy, done} !== {ew, ec, eb, edn}) begin
                miscompares++;
                $display("FAIL basic_cycle%0d: we/cen/busy/done=%b%b%b%b expected %b%b%b%b",
                         k, lgn_we, sram_cen, busy, done, ew, ec, eb, edn);
            end
        end
        vectors++;
        if (strobes != 4 || exp_data.size() != 0 || exp_addr.size() != 0) begin
            miscompares++;
            $display("FAIL basic_count: strobes=%0d left data=%0d addr=%0d, expected 4/0/0",
                     strobes, exp_data.size(), exp_addr.size());
        end
    endtask

    // Address wrap 510 -> 511 -> 0; start and abort together must still start.
    task automatic test_wrap();
        mem[510] = 8'hA5; mem[511] = 8'h5A; mem[0] = 8'hC3;
        exp_data = '{8'hA5, 8'h5A, 8'hC3};
        exp_addr = '{9'd510, 9'd511, 9'd0};
        strobes = 0;
        base_addr = 9'd510; length = 10'd3; start = 1'b1; abort = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            start = 1'b0; abort = 1'b0;
            vectors++;
            if (done !== (k == 12)) begin
                miscompares++;
                $display("FAIL wrap_done cycle%0d: got %b expected %b", k, done, (k == 12));
            end
        end
        vectors++;
        if (strobes != 3 || exp_data.size() != 0 || exp_addr.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_count: strobes=%0d left data=%0d addr=%0d, expected 3/0/0",
                     strobes, exp_data.size(), exp_addr.size());
        end
    endtask

    task automatic test_zero_length();
        base_addr = 9'd7; length = 10'd0; start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            start = 1'b0;
            vectors++;
            if ({done, busy, sram_cen, lgn_we} !== {(k == 1), 1'b0, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL zero_len cycle%0d: done/busy/cen/we=%b%b%b%b expected %b010",
                         k, done, busy, sram_cen, lgn_we, (k == 1));
            end
        end
    endtask

    // Abort in GAP after the second strobe.
    task automatic test_abort();
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        exp_data = '{8'h11, 8'h22};
        exp_addr = '{9'd0, 9'd1};
        strobes = 0;
        base_addr = 9'd0; length = 10'd4; start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            start = 1'b0;
            if (k == 9) abort = 1'b0;
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_done cycle%0d: got %b expected 0", k, done);
            end
            if (k >= 9) begin
                vectors++;
                if ({busy, sram_cen, lgn_we} !== 3'b010) begin
                    miscompares++;
                    $display("FAIL abort_idle cycle%0d: busy/cen/we=%b%b%b expected 010",
                             k, busy, sram_cen, lgn_we);
                end
            end
            if (k == 8) abort = 1'b1;
        end
        vectors++;
        if (strobes != 2 || exp_data.size() != 0 || exp_addr.size() != 0) begin
            miscompares++;
            $display("FAIL abort_count: strobes=%0d left data=%0d addr=%0d, expected 2/0/0",
                     strobes, exp_data.size(), exp_addr.size());
        end
    endtask

    // A second start mid-transfer must not relatch base/length.
    task automatic test_start_while_busy();
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        mem[100] = 8'hEE; mem[101] = 8'hDD;
        exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_addr = '{9'd0, 9'd1, 9'd2, 9'd3};
        strobes = 0;
        base_addr = 9'd0; length = 10'd4; start = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            start = 1'b0;
            vectors++;
            if (done !== (k == 16)) begin
                miscompares++;
                $display("FAIL busy_start_done cycle%0d: got %b expected %b", k, done, (k == 16));
            end
            if (k == 5) begin
                start = 1'b1; base_addr = 9'd100; length = 10'd2;
            end
        end
        vectors++;
        if (strobes != 4 || exp_data.size() != 0 || exp_addr.size() != 0) begin
            miscompares++;
            $display("FAIL busy_start_count: strobes=%0d left data=%0d addr=%0d, expected 4/0/0",
                     strobes, exp_data.size(), exp_addr.size());
        end
    endtask

    // Reset pulse while in GAP, then a fresh transfer.
    task automatic test_reset_in_gap();
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_addr = '{9'd0, 9'd1, 9'd2, 9'd3};
        base_addr = 9'd0; length = 10'd4; start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            start = 1'b0;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if ({sram_cen, sram_a, lgn_we, lgn_data, busy, done}
            !== {1'b1, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL gap_reset: cen=%b a=%0d we=%b data=%h busy=%b done=%b",
                     sram_cen, sram_a, lgn_we, lgn_data, busy, done);
        end
        exp_data.delete();
        exp_addr.delete();
        for (int k = 0; k < 3; k++) tick();
        test_basic();
    endtask

    initial begin
        test_reset();
        test_basic();
        tick(); tick();
        test_wrap();
        tick(); tick();
        test_zero_length();
        tick(); tick();
        test_abort();
        tick(); tick();
        test_start_while_busy();
        tick(); tick();
        test_reset_in_gap();
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
